// File: rtl/mul_result_stage.sv
// rtl/mul_result_stage.sv - RV64M result stage: signed high-half correction and writeback handshake
// Optional completion counter on done_cnt when MULRES_STATS_EN is defined.
module mul_result_stage #(
  parameter int XLEN = 64
`ifdef MULRES_STATS_EN
  , parameter int CNT_W = 32
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2*XLEN-1:0] product,
  input  logic [XLEN-1:0]   a,
  input  logic [XLEN-1:0]   b,
  input  logic [1:0]        op,
  input  logic              is_word,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   result
`ifdef MULRES_STATS_EN
  , output logic [CNT_W-1:0] done_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, CORR_A, CORR_B, DONE} state_t;

  state_t            state_q;
  logic [XLEN-1:0]   hi_q, lo_q, a_q, b_q, result_q;
  logic [1:0]        op_q;
  logic              is_word_q, in_ready_q, out_valid_q;
  logic [XLEN-1:0]   sub_rhs, hi_d;
  logic              need_a_in, need_b_in, need_b_q, word_in;
`ifdef MULRES_STATS_EN
  logic [CNT_W-1:0]  done_cnt_q;
`endif

  // MULW is only honoured with op=00; any other op treats is_word as 0.
  function automatic logic [XLEN-1:0] fmt_result(input logic [1:0] op_v, input logic word_v,
                                                 input logic [XLEN-1:0] hi_v,
                                                 input logic [XLEN-1:0] lo_v);
    if (op_v == 2'b00)
      return word_v ? {{(XLEN-32){lo_v[31]}}, lo_v[31:0]} : lo_v;
    return hi_v;
  endfunction

  // Single subtractor shared between the two correction steps.
  always_comb begin
    sub_rhs   = (state_q == CORR_A) ? b_q : a_q;
    hi_d      = hi_q - sub_rhs;
    need_a_in = a[XLEN-1] && (op == 2'b01 || op == 2'b10);
    need_b_in = b[XLEN-1] && (op == 2'b01);
    word_in   = is_word && (op == 2'b00);
    need_b_q  = b_q[XLEN-1] && (op_q == 2'b01);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      hi_q        <= '0;
      lo_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= 2'b00;
      is_word_q   <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      result_q    <= '0;
`ifdef MULRES_STATS_EN
      done_cnt_q  <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            hi_q       <= product[2*XLEN-1:XLEN];
            lo_q       <= product[XLEN-1:0];
            a_q        <= a;
            b_q        <= b;
            op_q       <= op;
            is_word_q  <= word_in;
            in_ready_q <= 1'b0;
            if (need_a_in) begin
              state_q <= CORR_A;
            end else if (need_b_in) begin
              state_q <= CORR_B;
            end else begin
              state_q     <= DONE;
              out_valid_q <= 1'b1;
              result_q    <= fmt_result(op, word_in, product[2*XLEN-1:XLEN], product[XLEN-1:0]);
            end
          end
        end
        CORR_A: begin
          hi_q <= hi_d;
          if (need_b_q) begin
            state_q <= CORR_B;
          end else begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
            result_q    <= fmt_result(op_q, is_word_q, hi_d, lo_q);
          end
        end
        CORR_B: begin
          hi_q        <= hi_d;
          state_q     <= DONE;
          out_valid_q <= 1'b1;
          result_q    <= fmt_result(op_q, is_word_q, hi_d, lo_q);
        end
        DONE: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
`ifdef MULRES_STATS_EN
            done_cnt_q  <= done_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
`endif
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = result_q;
`ifdef MULRES_STATS_EN
  assign done_cnt  = done_cnt_q;
`endif

endmodule

// File: tb/tb_mul_result_stage.sv
// tb/tb_mul_result_stage.sv - directed self-checking bench for mul_result_stage
module tb_mul_result_stage;

  logic         clk = 1'b0;
  logic         rst_n, in_valid, in_ready, out_valid, out_ready, is_word;
  logic [127:0] product;
  logic [63:0]  a, b, result;
  logic [1:0]   op;
`ifdef MULRES_STATS_EN
  logic [31:0]  done_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [63:0] ALL1 = 64'hFFFF_FFFF_FFFF_FFFF;

  mul_result_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .product(product), .a(a), .b(b), .op(op), .is_word(is_word),
    .out_valid(out_valid), .out_ready(out_ready), .result(result)
`ifdef MULRES_STATS_EN
    , .done_cnt(done_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset(input int cycles);
    rst_n = 1'b0;
    repeat (cycles) tick();
    rst_n = 1'b1;
  endtask

  // Accept one op, measure latency to out_valid, check result, then complete handshake.
  task automatic run_op(input string tag, input logic [63:0] av, input logic [63:0] bv,
                        input logic [127:0] pv, input logic [1:0] opv, input logic wv,
                        input logic [63:0] exp_res, input int exp_lat);
    int lat;
    int guard;
    guard = 0;
    while (!in_ready && guard < 20) begin
      tick();
      guard++;
    end
    check({tag, "_in_ready"}, {63'd0, in_ready}, 64'd1);
    a = av; b = bv; product = pv; op = opv; is_word = wv; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    a = '0; b = '0; product = '0; op = 2'b00; is_word = 1'b0;
    lat = 1;
    while (!out_valid && lat < 8) begin
      tick();
      lat++;
    end
    check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    check({tag, "_result"}, result, exp_res);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_valid_drop"}, {63'd0, out_valid}, 64'd0);
    check({tag, "_ready_back"}, {63'd0, in_ready}, 64'd1);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; is_word = 1'b0;
    product = '0; a = '0; b = '0; op = 2'b00;

    apply_reset(2);
    check("reset_in_ready", {63'd0, in_ready}, 64'd1);
    check("reset_out_valid", {63'd0, out_valid}, 64'd0);
    check("reset_result", result, 64'd0);
`ifdef MULRES_STATS_EN
    check("reset_done_cnt", 64'(done_cnt), 64'd0);
`endif

    run_op("mulh_a", ALL1, 64'd2, 128'h1_FFFF_FFFF_FFFF_FFFE, 2'b01, 1'b0, ALL1, 2);
    run_op("mulh_ab", ALL1, ALL1, 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001,
           2'b01, 1'b0, 64'd0, 3);
    run_op("mulhu", ALL1, ALL1, 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001,
           2'b11, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 1);
    run_op("mulw", 64'h8000_0000, 64'd1, 128'h8000_0000, 2'b00, 1'b1,
           64'hFFFF_FFFF_8000_0000, 1);
    run_op("mul32", 64'h8000_0000, 64'd1, 128'h8000_0000, 2'b00, 1'b0,
           64'h0000_0000_8000_0000, 1);
    run_op("mulhu_word_ign", ALL1, ALL1, 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001,
           2'b11, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1);

    // MULHSU held under backpressure while upstream keeps presenting a new op.
    apply_reset(1);
    a = ALL1; b = 64'd2; product = 128'h1_FFFF_FFFF_FFFF_FFFE; op = 2'b10; in_valid = 1'b1;
    tick();
    a = 64'd3; b = 64'd5; product = 128'd15; op = 2'b00;
    check("hsu_corr_in_ready", {63'd0, in_ready}, 64'd0);
    tick();
    check("hsu_latency2_valid", {63'd0, out_valid}, 64'd1);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("hsu_hold_result_%0d", i), result, ALL1);
      check($sformatf("hsu_hold_valid_%0d", i), {63'd0, out_valid}, 64'd1);
      check($sformatf("hsu_hold_in_ready_%0d", i), {63'd0, in_ready}, 64'd0);
`ifdef MULRES_STATS_EN
      check($sformatf("hsu_hold_cnt_%0d", i), 64'(done_cnt), 64'd0);
`endif
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("hsu_single_handshake", {63'd0, out_valid}, 64'd0);
    check("hsu_in_ready_after", {63'd0, in_ready}, 64'd1);
    check("hsu_result_held", result, ALL1);
`ifdef MULRES_STATS_EN
    check("hsu_done_cnt", 64'(done_cnt), 64'd1);
`endif
    tick();
    check("hsu_no_stray_accept", {63'd0, in_ready}, 64'd1);

    // Reset while the MULH is in its first correction step.
    a = ALL1; b = 64'd2; product = 128'h1_FFFF_FFFF_FFFF_FFFE; op = 2'b01; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("midrst_out_valid", {63'd0, out_valid}, 64'd0);
    check("midrst_in_ready", {63'd0, in_ready}, 64'd1);
    check("midrst_result", result, 64'd0);
`ifdef MULRES_STATS_EN
    check("midrst_done_cnt", 64'(done_cnt), 64'd0);
`endif
    tick();
    check("midrst_stays_idle", {63'd0, out_valid}, 64'd0);
    run_op("mul_after_rst", 64'd3, 64'd5, 128'd15, 2'b00, 1'b0, 64'd15, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
